pea_result_drain: RTL and testbench

Downstream stage of the PEA output FIFOs (result and status, 32-bit words each). It pops one result word and one status word together and serialises the pair as one 4-beat packet onto a 16-bit valid/ready stream for the host side. It also keeps a packet count.

---
 rtl/pea_pkg.sv | 27 ++
 rtl/pea_beat_serializer.sv | 68 ++++++
 rtl/pea_result_drain.sv | 96 +++++++++
 tb/tb_pea_result_drain.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared types and constants for the PEA result drain
//
// Purpose: drain state encoding, beat-count helper and the packet beat order.
// The packet is packed as {result, status}, so status occupies the low beats
// and result the high beats; beats leave least-significant first.
package pea_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAP  = 2'd2,
    ST_SEND = 2'd3
  } pea_state_t;

  // Beats per packet: one status word plus one result word.
  function automatic int calc_nbeat(input int width, input int out_w);
    return (2 * width) / out_w;
  endfunction

  // First beat index of each half of the packet.
  localparam int STATUS_BASE_BEAT = 0;

  function automatic int result_base_beat(input int width, input int out_w);
    return width / out_w;
  endfunction

endpackage

// File: rtl/pea_beat_serializer.sv
// rtl/pea_beat_serializer.sv - load-then-shift-out beat serializer
//
// Purpose: captures one {result, status} packet on i_load and presents it as
// NBEAT beats on a valid/ready stream, least-significant beat first.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_load              parallel load; starts a new packet at beat 0
//   i_result, i_status  words to capture on i_load
//   i_ready             sink accepts the current beat
//   o_data              current beat
//   o_valid, o_last     beat valid, final beat of packet
//   o_done              final beat accepted this cycle
module pea_beat_serializer
  import pea_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_result,
  input  logic [WIDTH-1:0] i_status,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_done
);

  localparam int NBEAT = calc_nbeat(WIDTH, OUT_W);
  localparam int BI_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  logic [2*WIDTH-1:0] r_pkt;
  logic [BI_W-1:0]    r_beat;
  logic               r_valid;
  logic               w_accept;
  logic               w_last;

  assign w_accept = r_valid & i_ready;
  assign w_last   = r_valid && (r_beat == BI_W'(NBEAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pkt   <= {i_result, i_status};
      r_beat  <= '0;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_beat  <= '0;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Data and last come only from registers, so they hold during a stall.
  assign o_data  = r_pkt[int'(r_beat) * OUT_W +: OUT_W];
  assign o_valid = r_valid;
  assign o_last  = w_last;
  assign o_done  = w_accept & w_last;

endmodule

// File: rtl/pea_result_drain.sv
// rtl/pea_result_drain.sv - drains result/status FIFOs into a packet stream
//
// Purpose: pops one result and one status word together and sends them as
// one NBEAT-beat packet on a valid/ready stream; counts completed packets.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   en                         allows a new packet to start
//   result_pop, status_pop     FIFO populations
//   result_data, status_data   FIFO read data, valid the cycle after the pop
//   rd_en_result, rd_en_status joint one-cycle pop strobes
//   out_data/out_valid/out_ready/out_last  packet stream
//   pkt_count                  completed packets, wrapping
//   busy                       FSM not idle
module pea_result_drain
  import pea_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OUT_W = 16,
  parameter int POP_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  input  logic [WIDTH-1:0] result_data,
  input  logic [WIDTH-1:0] status_data,
  output logic             rd_en_result,
  output logic             rd_en_status,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy
);

  pea_state_t       r_state;
  pea_state_t       w_next;
  logic             w_done;
  logic [CNT_W-1:0] r_pkt_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Population is looked at only in IDLE, by which time the previous pop has
  // already been reflected, so an emptied FIFO is never popped again.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (en && (result_pop != '0) && (status_pop != '0)) w_next = ST_POP;
      ST_POP:  w_next = ST_CAP;
      ST_CAP:  w_next = ST_SEND;
      ST_SEND: if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Both strobes decode from the same state, so they can never separate.
  assign rd_en_result = (r_state == ST_POP);
  assign rd_en_status = (r_state == ST_POP);
  assign busy         = (r_state != ST_IDLE);

  pea_beat_serializer #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_state == ST_CAP),
    .i_result (result_data),
    .i_status (status_data),
    .i_ready  (out_ready),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .o_last   (out_last),
    .o_done   (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
    end else if (w_done) begin
      r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_pea_result_drain.sv
// tb/tb_pea_result_drain.sv - self-checking bench for pea_result_drain
module tb_pea_result_drain;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  result_pop = '0;
  logic [4:0]  status_pop = '0;
  logic [31:0] result_data = '0;
  logic [31:0] status_data = '0;
  logic        rd_en_result, rd_en_status;
  logic [15:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [15:0] pkt_count;
  logic        busy;

  // Narrow-counter instance in lockstep with the main one, for the wrap check.
  logic        w2_rd_r, w2_rd_s, w2_valid, w2_last, w2_busy;
  logic [15:0] w2_data;
  logic [1:0]  w2_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int busy_seen = 0;
  int exp_cnt = 0;
  int rd_times[$];
  int vr_times[$];
  logic prev_valid = 1'b0;
  logic [31:0] res_q[$];
  logic [31:0] stat_q[$];
  beat_t exp_q[$];

  pea_result_drain dut (
    .clk(clk), .rst(rst), .en(en),
    .result_pop(result_pop), .status_pop(status_pop),
    .result_data(result_data), .status_data(status_data),
    .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .pkt_count(pkt_count), .busy(busy)
  );

  pea_result_drain #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en),
    .result_pop(result_pop), .status_pop(status_pop),
    .result_data(result_data), .status_data(status_data),
    .rd_en_result(w2_rd_r), .rd_en_status(w2_rd_s),
    .out_data(w2_data), .out_valid(w2_valid), .out_ready(out_ready),
    .out_last(w2_last), .pkt_count(w2_cnt), .busy(w2_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host-side model and FIFO model, all sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (rd_en_result || rd_en_status) begin
        chk("rd_en_pair", rd_en_status, rd_en_result);
        rd_cnt++;
        rd_times.push_back(cyc);
        chk("pop_nonempty", (res_q.size() != 0) && (stat_q.size() != 0), 1);
        if (res_q.size() != 0) result_data = res_q.pop_front();
        if (stat_q.size() != 0) status_data = stat_q.pop_front();
      end
      if (busy) busy_seen = 1;
      if (out_valid && !prev_valid) vr_times.push_back(cyc);
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", out_data, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
          if (e.last) exp_cnt++;
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
    result_pop = (res_q.size() > 31) ? 5'd31 : 5'(res_q.size());
    status_pop = (stat_q.size() > 31) ? 5'd31 : 5'(stat_q.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic [31:0] s);
    exp_q.push_back('{data: s[15:0],  last: 1'b0});
    exp_q.push_back('{data: s[31:16], last: 1'b0});
    exp_q.push_back('{data: r[15:0],  last: 1'b0});
    exp_q.push_back('{data: r[31:16], last: 1'b1});
  endtask

  task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
    res_q.push_back(r);
    stat_q.push_back(s);
    push_exp(r, s);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    chk("valid_timeout", n < max, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_q;
    int rd0;
    beat_t e;

    // Reset state
    repeat (3) tick();
    chk("rst_rd_en", rd_en_result, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Single packet with latency
    en = 1'b1;
    out_ready = 1'b1;
    rd_times.delete();
    vr_times.delete();
    t_q = cyc;
    push_pair(32'h0001_0005, 32'h0000_0001);
    drain(50);
    chk("single_rd_pulses", rd_times.size(), 1);
    if (rd_times.size() > 0) chk("single_rd_lat", rd_times[0] - t_q, 1);
    if (vr_times.size() > 0) chk("single_valid_lat", vr_times[0] - t_q, 3);
    chk("single_count", pkt_count, 1);
    chk("single_model_count", pkt_count, exp_cnt);

    // Backpressure on beat 1
    push_pair(32'h0001_0005, 32'h0000_0001);
    wait_valid(20);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", out_data, 16'h0000);
      chk("stall_valid", out_valid, 1);
      chk("stall_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    drain(50);
    chk("bp_count", pkt_count, 2);

    // Mismatched population
    rd0 = rd_cnt;
    busy_seen = 0;
    res_q.push_back(32'hA1A1_B2B2);
    res_q.push_back(32'hC3C3_D4D4);
    repeat (20) tick();
    chk("mm_no_pop", rd_cnt, rd0);
    chk("mm_not_busy", busy_seen, 0);
    vr_times.delete();
    stat_q.push_back(32'h1111_2222);
    stat_q.push_back(32'h3333_4444);
    push_exp(32'hA1A1_B2B2, 32'h1111_2222);
    push_exp(32'hC3C3_D4D4, 32'h3333_4444);
    drain(60);
    chk("mm_two_pkts", vr_times.size(), 2);
    if (vr_times.size() == 2) chk("mm_spacing", vr_times[1] - vr_times[0], 7);
    chk("mm_count", pkt_count, 4);

    // en gating
    en = 1'b0;
    rd0 = rd_cnt;
    push_pair(32'h5555_6666, 32'h7777_8888);
    repeat (10) tick();
    chk("en_no_pop", rd_cnt, rd0);
    en = 1'b1;
    wait_valid(20);
    en = 1'b0;
    push_pair(32'h9999_AAAA, 32'hBBBB_CCCC);
    for (int n = 0; n < 40 && exp_q.size() > 4; n++) tick();
    repeat (2) tick();
    rd0 = rd_cnt;
    busy_seen = 0;
    repeat (15) tick();
    chk("en_drop_count", pkt_count, 5);
    chk("en_drop_no_new", rd_cnt, rd0);
    chk("en_drop_idle", busy_seen, 0);

    // Reset during beat 2
    en = 1'b1;
    wait_valid(20);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", rd_en_result | rd_en_status, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", pkt_count, 0);
    do begin
      e = exp_q.pop_front();
    end while (!e.last && exp_q.size() != 0);
    exp_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    push_pair(32'hFEDC_BA98, 32'h7654_3210);
    drain(50);
    chk("post_rst_count", pkt_count, 1);
    chk("post_rst_model_count", pkt_count, exp_cnt);

    // Counter wrap on the narrow instance
    chk("wrap_start", w2_cnt, 1);
    for (int i = 0; i < 2; i++) begin
      push_pair($urandom, $urandom);
      drain(50);
    end
    chk("wrap_max", w2_cnt, 3);
    push_pair($urandom, $urandom);
    drain(50);
    chk("wrap_zero", w2_cnt, 0);
    chk("wrap_main_count", pkt_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
